// File: rtl/cam_write_arbiter.sv
// Merges the pixel-write streams of two cameras onto one frame-buffer write port.
//
// Split mode (mode[1]=1): each camera pushes into its own small FIFO. A round-robin
// scheduler pops at most one entry per cycle. Camera 1 lands on the left half of the frame
// and camera 0 on the right half.
//
// Pass-through (mode[1]=0): the selected camera is registered straight to the outputs.
//   - 01 selects cam0.
//   - 00 selects cam1.
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   i_mode                        1x split, 01 cam0 only, 00 cam1 only
//   i_we/data/line/pixel_camN     per-camera pixel write
//   i_imag_depth/width_camN       per-camera image geometry
//   o_we, o_data_wr, o_line,
//   o_pixel                       frame-buffer write
//   o_imag_depth, o_imag_width    output frame geometry
//   o_grant                       source of the current o_we (0=cam0, 1=cam1)
//   o_ovf_cam0/1                  sticky FIFO overflow, cleared by reset or mode change
module cam_write_arbiter #(
  parameter int unsigned CAM_DATA_WIDTH = 12,
  parameter int unsigned CAM_LINE       = 9,
  parameter int unsigned CAM_PIXEL      = 10,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned HALF_WIDTH     = 160,
  parameter int unsigned OUT_DEPTH      = 240
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                i_mode,
  input  logic                      i_we_cam0,
  input  logic                      i_we_cam1,
  input  logic [CAM_DATA_WIDTH-1:0] i_data_cam0,
  input  logic [CAM_DATA_WIDTH-1:0] i_data_cam1,
  input  logic [CAM_LINE-1:0]       i_line_cam0,
  input  logic [CAM_LINE-1:0]       i_line_cam1,
  input  logic [CAM_PIXEL-1:0]      i_pixel_cam0,
  input  logic [CAM_PIXEL-1:0]      i_pixel_cam1,
  input  logic [CAM_LINE-1:0]       i_imag_depth_cam0,
  input  logic [CAM_LINE-1:0]       i_imag_depth_cam1,
  input  logic [CAM_PIXEL-1:0]      i_imag_width_cam0,
  input  logic [CAM_PIXEL-1:0]      i_imag_width_cam1,
  output logic                      o_we,
  output logic [CAM_DATA_WIDTH-1:0] o_data_wr,
  output logic [CAM_LINE-1:0]       o_line,
  output logic [CAM_PIXEL-1:0]      o_pixel,
  output logic [CAM_LINE-1:0]       o_imag_depth,
  output logic [CAM_PIXEL-1:0]      o_imag_width,
  output logic                      o_grant,
  output logic                      o_ovf_cam0,
  output logic                      o_ovf_cam1
);

  localparam int unsigned PtrW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned EntryW = CAM_DATA_WIDTH + CAM_LINE + CAM_PIXEL;

  localparam logic [CntW-1:0]      CntFull  = CntW'(FIFO_DEPTH);
  localparam logic [CAM_PIXEL-1:0] HalfW    = CAM_PIXEL'(HALF_WIDTH);
  localparam logic [CAM_PIXEL-1:0] HalfMax  = CAM_PIXEL'(HALF_WIDTH - 1);
  localparam logic [CAM_PIXEL-1:0] FullW    = CAM_PIXEL'(2 * HALF_WIDTH);
  localparam logic [CAM_LINE-1:0]  OutDepth = CAM_LINE'(OUT_DEPTH);

  logic [1:0] mode_q;
  logic       mode_change;
  logic       split;

  // While i_mode differs from mode_q the cycle is a flush cycle, so mode_q is the mode in force.
  assign mode_change = (i_mode != mode_q);
  assign split       = mode_q[1];

  // Enqueue mapping: clamp to one half-screen, and move cam0 onto the right half.
  logic [CAM_PIXEL-1:0] pix_clamp0, pix_clamp1, pix_map0;
  logic [EntryW-1:0]    entry_in [2];
  logic [1:0]           we_in;

  always_comb begin
    pix_clamp0  = (i_pixel_cam0 > HalfMax) ? HalfMax : i_pixel_cam0;
    pix_clamp1  = (i_pixel_cam1 > HalfMax) ? HalfMax : i_pixel_cam1;
    pix_map0    = pix_clamp0 + HalfW;
    entry_in[0] = {i_data_cam0, i_line_cam0, pix_map0};
    entry_in[1] = {i_data_cam1, i_line_cam1, pix_clamp1};
    we_in       = {i_we_cam1, i_we_cam0};
  end

  // FIFO state.
  logic [EntryW-1:0]    mem_q [2][FIFO_DEPTH];
  logic [1:0][PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [1:0][CntW-1:0] cnt_q;
  logic [1:0]           not_empty, full, push, pop, ovf_set;
  logic                 grant, any_pop, rr_q, rr_d;
  logic [EntryW-1:0]    head;

  // Scheduler and FIFO control.
  always_comb begin
    not_empty = '0;
    full      = '0;
    push      = '0;
    pop       = '0;
    ovf_set   = '0;
    grant     = 1'b0;
    any_pop   = 1'b0;
    rr_d      = rr_q;
    for (int c = 0; c < 2; c++) begin
      not_empty[c] = (cnt_q[c] != '0);
      full[c]      = (cnt_q[c] == CntFull);
    end
    if (split && !mode_change) begin
      any_pop = |not_empty;
      if (&not_empty) begin
        grant = rr_q;
        rr_d  = ~rr_q;
      end else begin
        grant = not_empty[1];
      end
      pop[0] = any_pop & ~grant;
      pop[1] = any_pop & grant;
      for (int c = 0; c < 2; c++) begin
        // A full FIFO popped this cycle has room for the push.
        push[c]    = we_in[c] & (~full[c] | pop[c]);
        ovf_set[c] = we_in[c] & full[c] & ~pop[c];
      end
    end
  end

  assign head = mem_q[grant][rd_ptr_q[grant]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= 2'b00;
      rr_q     <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mode_q <= i_mode;
      rr_q   <= rr_d;
      if (mode_change) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        for (int c = 0; c < 2; c++) begin
          if (push[c]) wr_ptr_q[c] <= wr_ptr_q[c] + PtrW'(1);
          if (pop[c])  rd_ptr_q[c] <= rd_ptr_q[c] + PtrW'(1);
          cnt_q[c] <= cnt_q[c] + CntW'(push[c]) - CntW'(pop[c]);
        end
      end
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and counts.
  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (push[c]) mem_q[c][wr_ptr_q[c]] <= entry_in[c];
    end
  end

  // Output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_we         <= 1'b0;
      o_data_wr    <= '0;
      o_line       <= '0;
      o_pixel      <= '0;
      o_imag_depth <= '0;
      o_imag_width <= '0;
      o_grant      <= 1'b0;
      o_ovf_cam0   <= 1'b0;
      o_ovf_cam1   <= 1'b0;
    end else if (mode_change) begin
      o_we       <= 1'b0;
      o_ovf_cam0 <= 1'b0;
      o_ovf_cam1 <= 1'b0;
    end else if (split) begin
      o_we <= any_pop;
      if (any_pop) begin
        {o_data_wr, o_line, o_pixel} <= head;
        o_grant <= grant;
      end
      o_imag_depth <= OutDepth;
      o_imag_width <= FullW;
      o_ovf_cam0   <= o_ovf_cam0 | ovf_set[0];
      o_ovf_cam1   <= o_ovf_cam1 | ovf_set[1];
    end else if (mode_q[0]) begin
      o_we         <= i_we_cam0;
      o_data_wr    <= i_data_cam0;
      o_line       <= i_line_cam0;
      o_pixel      <= i_pixel_cam0;
      o_imag_depth <= i_imag_depth_cam0;
      o_imag_width <= i_imag_width_cam0;
      o_grant      <= 1'b0;
    end else begin
      o_we         <= i_we_cam1;
      o_data_wr    <= i_data_cam1;
      o_line       <= i_line_cam1;
      o_pixel      <= i_pixel_cam1;
      o_imag_depth <= i_imag_depth_cam1;
      o_imag_width <= i_imag_width_cam1;
      o_grant      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cam_write_arbiter.sv
// Directed bench for cam_write_arbiter at default parameters.
module tb_cam_write_arbiter;

  logic        clk, rst_n;
  logic [1:0]  i_mode;
  logic        i_we_cam0, i_we_cam1;
  logic [11:0] i_data_cam0, i_data_cam1;
  logic [8:0]  i_line_cam0, i_line_cam1;
  logic [9:0]  i_pixel_cam0, i_pixel_cam1;
  logic [8:0]  i_imag_depth_cam0, i_imag_depth_cam1;
  logic [9:0]  i_imag_width_cam0, i_imag_width_cam1;
  logic        o_we;
  logic [11:0] o_data_wr;
  logic [8:0]  o_line;
  logic [9:0]  o_pixel;
  logic [8:0]  o_imag_depth;
  logic [9:0]  o_imag_width;
  logic        o_grant, o_ovf_cam0, o_ovf_cam1;

  int n_checks = 0;
  int n_fail   = 0;
  logic [30:0] exp_q0[$];
  logic [30:0] exp_q1[$];

  cam_write_arbiter dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_mode            (i_mode),
    .i_we_cam0         (i_we_cam0),
    .i_we_cam1         (i_we_cam1),
    .i_data_cam0       (i_data_cam0),
    .i_data_cam1       (i_data_cam1),
    .i_line_cam0       (i_line_cam0),
    .i_line_cam1       (i_line_cam1),
    .i_pixel_cam0      (i_pixel_cam0),
    .i_pixel_cam1      (i_pixel_cam1),
    .i_imag_depth_cam0 (i_imag_depth_cam0),
    .i_imag_depth_cam1 (i_imag_depth_cam1),
    .i_imag_width_cam0 (i_imag_width_cam0),
    .i_imag_width_cam1 (i_imag_width_cam1),
    .o_we              (o_we),
    .o_data_wr         (o_data_wr),
    .o_line            (o_line),
    .o_pixel           (o_pixel),
    .o_imag_depth      (o_imag_depth),
    .o_imag_width      (o_imag_width),
    .o_grant           (o_grant),
    .o_ovf_cam0        (o_ovf_cam0),
    .o_ovf_cam1        (o_ovf_cam1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_we_cam0 = 1'b0;
    i_we_cam1 = 1'b0;
  endtask

  // One isolated split-mode write: latency, mapping, grant, geometry and hold.
  task automatic split_one(input bit cam, input int pix, input int exp_pix, input string tag);
    if (cam) begin
      i_we_cam1 = 1'b1; i_pixel_cam1 = 10'(pix); i_line_cam1 = 9'd7; i_data_cam1 = 12'h2C3;
    end else begin
      i_we_cam0 = 1'b1; i_pixel_cam0 = 10'(pix); i_line_cam0 = 9'd7; i_data_cam0 = 12'h2C3;
    end
    step();
    check_eq({tag, "_lat"}, 32'(o_we), 0);
    idle();
    step();
    check_eq({tag, "_we"}, 32'(o_we), 1);
    check_eq({tag, "_pix"}, 32'(o_pixel), exp_pix);
    check_eq({tag, "_data"}, 32'(o_data_wr), 32'h2C3);
    check_eq({tag, "_grant"}, 32'(o_grant), 32'(cam));
    check_eq({tag, "_depth"}, 32'(o_imag_depth), 240);
    check_eq({tag, "_width"}, 32'(o_imag_width), 320);
    step();
    check_eq({tag, "_hold_we"}, 32'(o_we), 0);
    check_eq({tag, "_hold_pix"}, 32'(o_pixel), exp_pix);
  endtask

  // Scoreboard: every granted write must match the oldest outstanding entry of its camera.
  task automatic sb_sample(input string tag);
    logic [30:0] got;
    logic [30:0] exp;
    if (o_we) begin
      got = {o_data_wr, o_line, o_pixel};
      if (o_grant) begin
        if (exp_q1.size() == 0) check_eq({tag, "_extra_cam1"}, 32'(got), 32'hFFFF_FFFF);
        else begin
          exp = exp_q1.pop_front();
          check_eq({tag, "_cam1"}, 32'(got), 32'(exp));
        end
      end else begin
        if (exp_q0.size() == 0) check_eq({tag, "_extra_cam0"}, 32'(got), 32'hFFFF_FFFF);
        else begin
          exp = exp_q0.pop_front();
          check_eq({tag, "_cam0"}, 32'(got), 32'(exp));
        end
      end
    end
  endtask

  initial begin
    int j, cam, idx, p, ep;
    rst_n = 1'b0;
    i_mode = 2'b00;
    idle();
    i_data_cam0 = '0; i_data_cam1 = '0; i_line_cam0 = '0; i_line_cam1 = '0;
    i_pixel_cam0 = '0; i_pixel_cam1 = '0;
    i_imag_depth_cam0 = '0; i_imag_depth_cam1 = '0;
    i_imag_width_cam0 = '0; i_imag_width_cam1 = '0;

    // Reset state.
    #2;
    check_eq("rst_we", 32'(o_we), 0);
    check_eq("rst_depth", 32'(o_imag_depth), 0);
    check_eq("rst_width", 32'(o_imag_width), 0);
    #6 rst_n = 1'b1;
    step();
    check_eq("rst_idle_we", 32'(o_we), 0);

    // T2 pass-through cam0; input during the mode-change cycle is discarded.
    i_mode = 2'b01;
    i_we_cam0 = 1'b1; i_pixel_cam0 = 10'd200; i_line_cam0 = 9'd10; i_data_cam0 = 12'hABC;
    i_imag_depth_cam0 = 9'd100; i_imag_width_cam0 = 10'd200;
    i_we_cam1 = 1'b1; i_pixel_cam1 = 10'd7; i_line_cam1 = 9'd1; i_data_cam1 = 12'h123;
    i_imag_depth_cam1 = 9'd50; i_imag_width_cam1 = 10'd60;
    step();
    check_eq("t2_chg_we", 32'(o_we), 0);
    step();
    check_eq("t2_we", 32'(o_we), 1);
    check_eq("t2_pix", 32'(o_pixel), 200);
    check_eq("t2_line", 32'(o_line), 10);
    check_eq("t2_data", 32'(o_data_wr), 32'hABC);
    check_eq("t2_grant", 32'(o_grant), 0);
    check_eq("t2_depth", 32'(o_imag_depth), 100);
    check_eq("t2_width", 32'(o_imag_width), 200);
    i_we_cam0 = 1'b0;
    step();
    check_eq("t2_off_we", 32'(o_we), 0);
    repeat (6) step();
    check_eq("t2_ovf1", 32'(o_ovf_cam1), 0);
    check_eq("t2_ovf0", 32'(o_ovf_cam0), 0);

    // T3 split mapping.
    idle();
    i_mode = 2'b10;
    step();
    check_eq("t3_chg_we", 32'(o_we), 0);
    split_one(1'b0, 5, 165, "t3_c0_5");
    split_one(1'b0, 300, 319, "t3_c0_300");
    split_one(1'b1, 300, 159, "t3_c1_300");
    split_one(1'b0, 159, 319, "t3_c0_159");

    // T4 both cameras every cycle for 8 cycles, then drain.
    for (int t = 1; t <= 17; t++) begin
      if (t <= 8) begin
        i_we_cam0 = 1'b1; i_data_cam0 = 12'(256 + t - 1);
        i_line_cam0 = 9'(t - 1); i_pixel_cam0 = 10'(t - 1);
        i_we_cam1 = 1'b1; i_data_cam1 = 12'(512 + t - 1);
        i_line_cam1 = 9'(t - 1); i_pixel_cam1 = 10'(10 + t - 1);
      end else begin
        idle();
      end
      step();
      if (t >= 2 && t <= 16) begin
        j = t - 2;
        cam = j % 2;
        idx = j / 2;
        check_eq("t4_we", 32'(o_we), 1);
        check_eq("t4_grant", 32'(o_grant), cam);
        check_eq("t4_data", 32'(o_data_wr), (cam == 1) ? 512 + idx : 256 + idx);
        check_eq("t4_pix", 32'(o_pixel), (cam == 1) ? 10 + idx : 160 + idx);
      end else begin
        check_eq("t4_idle_we", 32'(o_we), 0);
      end
      if (t == 7) check_eq("t4_ovf1_pre", 32'(o_ovf_cam1), 0);
      if (t == 8) check_eq("t4_ovf1_set", 32'(o_ovf_cam1), 1);
      if (t == 17) begin
        check_eq("t4_ovf0_end", 32'(o_ovf_cam0), 0);
        check_eq("t4_ovf1_sticky", 32'(o_ovf_cam1), 1);
      end
    end

    // Mode change 10 -> 11 stays split but clears the sticky flag.
    i_mode = 2'b11;
    step();
    check_eq("chg11_we", 32'(o_we), 0);
    check_eq("chg11_ovf1", 32'(o_ovf_cam1), 0);

    // T5 interleaved writers.
    for (int t = 0; t < 1000; t++) begin
      if (t % 2 == 0) begin
        p = (t * 7) % 320;
        ep = ((p > 159) ? 159 : p) + 160;
        i_we_cam0 = 1'b1; i_we_cam1 = 1'b0;
        i_data_cam0 = 12'(t * 5 + 1); i_line_cam0 = 9'(t % 240); i_pixel_cam0 = 10'(p);
        exp_q0.push_back({12'(t * 5 + 1), 9'(t % 240), 10'(ep)});
      end else begin
        p = (t * 3) % 320;
        ep = (p > 159) ? 159 : p;
        i_we_cam0 = 1'b0; i_we_cam1 = 1'b1;
        i_data_cam1 = 12'(t * 11 + 3); i_line_cam1 = 9'(t % 240); i_pixel_cam1 = 10'(p);
        exp_q1.push_back({12'(t * 11 + 3), 9'(t % 240), 10'(ep)});
      end
      step();
      sb_sample("t5");
    end
    idle();
    repeat (4) begin
      step();
      sb_sample("t5_drain");
    end
    check_eq("t5_left0", 32'(exp_q0.size()), 0);
    check_eq("t5_left1", 32'(exp_q1.size()), 0);
    check_eq("t5_ovf0", 32'(o_ovf_cam0), 0);
    check_eq("t5_ovf1", 32'(o_ovf_cam1), 0);

    // T6 overfill, then switch to cam1 pass-through.
    for (int t = 0; t < 8; t++) begin
      i_we_cam0 = 1'b1; i_data_cam0 = 12'(t + 1);
      i_we_cam1 = 1'b1; i_data_cam1 = 12'(t + 2);
      step();
    end
    check_eq("t6_ovf_any", 32'(o_ovf_cam0 | o_ovf_cam1), 1);
    i_mode = 2'b00;
    step();
    check_eq("t6_chg_we", 32'(o_we), 0);
    check_eq("t6_ovf0_clr", 32'(o_ovf_cam0), 0);
    check_eq("t6_ovf1_clr", 32'(o_ovf_cam1), 0);
    idle();
    step();
    check_eq("t6_idle_we", 32'(o_we), 0);
    i_we_cam1 = 1'b1; i_pixel_cam1 = 10'd300; i_line_cam1 = 9'd5; i_data_cam1 = 12'h5A5;
    i_imag_depth_cam1 = 9'd123; i_imag_width_cam1 = 10'd456;
    step();
    check_eq("t6_we", 32'(o_we), 1);
    check_eq("t6_pix", 32'(o_pixel), 300);
    check_eq("t6_line", 32'(o_line), 5);
    check_eq("t6_data", 32'(o_data_wr), 32'h5A5);
    check_eq("t6_grant", 32'(o_grant), 1);
    check_eq("t6_depth", 32'(o_imag_depth), 123);
    check_eq("t6_width", 32'(o_imag_width), 456);

    // T1 reset mid-stream with queued entries.
    idle();
    i_mode = 2'b10;
    step();
    for (int t = 0; t < 3; t++) begin
      i_we_cam0 = 1'b1; i_data_cam0 = 12'(12'h0F0 + t); i_pixel_cam0 = 10'(t);
      i_we_cam1 = 1'b1; i_data_cam1 = 12'(12'h0E0 + t); i_pixel_cam1 = 10'(t + 1);
      step();
    end
    check_eq("t1_pre_we", 32'(o_we), 1);
    idle();
    #3 rst_n = 1'b0;
    #1;
    check_eq("t1_we", 32'(o_we), 0);
    check_eq("t1_data", 32'(o_data_wr), 0);
    check_eq("t1_line", 32'(o_line), 0);
    check_eq("t1_pix", 32'(o_pixel), 0);
    check_eq("t1_depth", 32'(o_imag_depth), 0);
    check_eq("t1_width", 32'(o_imag_width), 0);
    check_eq("t1_grant", 32'(o_grant), 0);
    check_eq("t1_ovf0", 32'(o_ovf_cam0), 0);
    check_eq("t1_ovf1", 32'(o_ovf_cam1), 0);
    #3 rst_n = 1'b1;
    for (int t = 0; t < 4; t++) begin
      step();
      check_eq("t1_post_we", 32'(o_we), 0);
    end
    split_one(1'b1, 20, 20, "t1_new");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
